// File: rtl/mont_pkg.sv
// Shared constants and types for the word-serial Montgomery reduction stage.
//
// N_BITS : modulus width, R = 2^N_BITS
// K      : digit width processed per iteration (N_BITS must be a multiple of K)
// WORDS  : iteration count, derived from N_BITS and K
// ACC_W  : accumulator width; one bit above the product so no carry is lost
// CNT_W  : width of the iteration counter
// state_e: reduction FSM states
package mont_pkg;

    localparam int N_BITS = 256;
    localparam int K      = 64;
    localparam int WORDS  = N_BITS / K;
    localparam int ACC_W  = 2 * N_BITS + 1;
    localparam int CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FINAL = 2'd2,
        OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/mont_digit_step.sv
// One Montgomery digit step (purely combinational).
//
//   m          = (acc[K-1:0] * n0_inv) mod 2^K
//   acc_next_o = (acc + m*n) >> K
//
// Ports:
//   acc_i      [ACC_W-1:0]  current accumulator
//   n_i        [N_BITS-1:0] modulus
//   n0_inv_i   [K-1:0]      -n^-1 mod 2^K
//   acc_next_o [ACC_W-1:0]  accumulator after this digit
module mont_digit_step
    import mont_pkg::*;
(
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [N_BITS-1:0] n_i,
    input  logic [K-1:0]      n0_inv_i,
    output logic [ACC_W-1:0]  acc_next_o
);

    localparam int MN_W  = K + N_BITS;
    localparam int SUM_W = ACC_W + 1;

    logic [K-1:0]     m;
    logic [MN_W-1:0]  mn;
    logic [SUM_W-1:0] sum;

    always_comb begin
        // K x K multiply; keeping only the low K bits gives m mod 2^K.
        m   = acc_i[K-1:0] * n0_inv_i;
        mn  = MN_W'(m) * MN_W'(n_i);
        // One spare bit above ACC_W so the add never drops a carry, even for
        // operands that break the preconditions.
        sum = SUM_W'(acc_i) + SUM_W'(mn);
        // Low K bits of sum are zero when n0_inv is correct; shift them out.
        acc_next_o = ACC_W'(sum >> K);
    end

endmodule

// File: rtl/mont_redc_512_to_256.sv
// Word-serial Montgomery reduction: result = t_in * R^-1 mod n, R = 2^N_BITS.
// Runs WORDS digit steps, then one conditional subtraction of n.
//
// Handshake (both sides): a transfer happens on the rising clk edge where
// valid and ready are both high; the producer holds valid and its data
// stable until that edge.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   in_valid    t_in / n / n0_inv valid
//   in_ready    high only in IDLE; operands are latched on acceptance
//   t_in        2*N_BITS product to reduce
//   n           N_BITS odd modulus
//   n0_inv      K-bit -n^-1 mod 2^K
//   out_valid   result valid, held until out_ready
//   out_ready   consumer accepts result
//   result      N_BITS reduced residue
module mont_redc_512_to_256
    import mont_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*N_BITS-1:0] t_in,
    input  logic [N_BITS-1:0]   n,
    input  logic [K-1:0]        n0_inv,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N_BITS-1:0]   result
);

    state_e             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [N_BITS-1:0]  n_q;
    logic [K-1:0]       n0_inv_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [N_BITS-1:0]  result_q;
    logic [N_BITS-1:0]  result_d;

    mont_digit_step u_step (
        .acc_i      (acc_q),
        .n_i        (n_q),
        .n0_inv_i   (n0_inv_q),
        .acc_next_o (acc_d)
    );

    // After the digit steps acc < 2n, so one subtraction is enough. The
    // difference fits in N_BITS, so only the low bits need subtracting.
    always_comb begin
        result_d = acc_q[N_BITS-1:0];
        if (acc_q >= ACC_W'(n_q)) begin
            result_d = acc_q[N_BITS-1:0] - n_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            n_q         <= '0;
            n0_inv_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        acc_q      <= ACC_W'(t_in);
                        n_q        <= n;
                        n0_inv_q   <= n0_inv;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ITER;
                    end
                end
                ITER: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WORDS - 1)) begin
                        state_q <= FINAL;
                    end
                end
                FINAL: begin
                    result_q    <= result_d;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule
